seq_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor: the next-generation successor to our fixed 4-bit ripple adder. Operands of WIDTH bits are processed CHUNK bits per clock, least-significant chunk first, with the carry held in a register between chunks. A start/busy/done handshake makes it usable as a shared arithmetic resource behind the datapath controller. It reports unsigned carry-out and signed overflow.

---
 rtl/seq_addsub.sv | 133 +++++++++++++
 tb/tb_seq_addsub.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// ----------------------------------------------------------------------------
// seq_addsub
//
// Multi-cycle adder/subtractor. A WIDTH-bit add or subtract is carried out
// CHUNK bits per clock, starting with the least-significant chunk. The carry
// between chunks is held in a register. The block is intended as a shared
// arithmetic resource with a start/busy/done handshake.
//
// Parameters
//   WIDTH  operand/result width; must be an integer multiple of CHUNK
//   CHUNK  bits processed per clock; 1 <= CHUNK <= WIDTH
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; only sampled while busy = 0
//   sub    in   0: a + b, 1: a - b (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when sum/cout/ovf become valid
//   sum    out  WIDTH-bit result, modulo 2^WIDTH
//   cout   out  carry out of the MSB (for sub: 1 = no borrow, a >= b unsigned)
//   ovf    out  signed overflow of the selected operation
//
// Latency is N = WIDTH/CHUNK cycles from the accepting edge to done. All
// outputs come straight from registers.
// ----------------------------------------------------------------------------
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // already inverted for subtraction
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_step;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic             w_last;
    logic             w_ovf;

    // NOTE: pure continuous assignments here, so no path can leave a signal
    // unassigned and infer a latch.
    assign w_a_chunk   = r_a[int'(r_step)*CHUNK +: CHUNK];
    assign w_b_chunk   = r_b[int'(r_step)*CHUNK +: CHUNK];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last      = (r_step == LAST_STEP);

    // On the final step, bit CHUNK-1 of the chunk sum is the result MSB.
    // Overflow: both effective operands share a sign that the result lacks.
    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                   (w_chunk_sum[CHUNK-1] != r_a[WIDTH-1]);

    // NOTE: non-blocking assignments throughout the clocked block. Each
    // register then takes its new value from the values present before the
    // edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_step  <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        // Subtraction is a + ~b + 1: invert b and seed carry.
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_step  <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[int'(r_step)*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
                    r_carry <= w_chunk_sum[CHUNK];
                    r_step  <= r_step + CW'(1);
                    if (w_last) begin
                        r_cout  <= w_chunk_sum[CHUNK];
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_step  <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_addsub.sv
// ----------------------------------------------------------------------------
// tb_seq_addsub
//
// Checks a directed WIDTH=16/CHUNK=4 instance (reset, arithmetic corners,
// ignored start, start in the done cycle, reset abort) and three randomised
// instances (16/16, 8/1, 32/8). A scoreboard queue per instance holds the
// expected results and is popped on every done pulse.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_addsub;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          t0;     // cycle count at the accepting edge
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic d_rst_n;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model in signed 64-bit arithmetic, independent of the chunking.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input int t0);
        exp_t   m;
        longint full, half, ua, ub, sa, sb, r;
        full = longint'(1) << w;
        half = full / 2;
        ua   = longint'(a) & (full - 1);
        ub   = longint'(b) & (full - 1);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        r    = sub ? sa - sb : sa + sb;
        m.sum  = 32'(r & (full - 1));
        m.cout = sub ? (ua >= ub) : ((ua + ub) >= full);
        m.ovf  = (r >= half) || (r < -half);
        m.t0   = t0;
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Directed instance, WIDTH=16, CHUNK=4
    // ------------------------------------------------------------------
    logic        d_start = 1'b0;
    logic        d_sub   = 1'b0;
    logic [15:0] d_a     = '0;
    logic [15:0] d_b     = '0;
    logic        d_busy, d_done, d_cout, d_ovf;
    logic [15:0] d_sum;
    exp_t        d_sb[$];

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk   (clk),
        .rst_n (d_rst_n),
        .start (d_start),
        .sub   (d_sub),
        .a     (d_a),
        .b     (d_b),
        .busy  (d_busy),
        .done  (d_done),
        .sum   (d_sum),
        .cout  (d_cout),
        .ovf   (d_ovf)
    );

    always @(negedge clk) begin
        if (d_done) begin
            if (d_sb.size() == 0) begin
                check("d_spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = d_sb.pop_front();
                check("d_sum", d_sum, e.sum);
                check("d_cout", d_cout, e.cout);
                check("d_ovf", d_ovf, e.ovf);
                check("d_latency", cycle - e.t0, 4);
            end
        end
    end

    // Called at a falling edge; start is seen by the next rising edge.
    task automatic d_issue(input logic [15:0] a, input logic [15:0] b, input logic sub);
        d_a     = a;
        d_b     = b;
        d_sub   = sub;
        d_start = 1'b1;
        d_sb.push_back(model(16, a, b, sub, cycle + 1));
        @(negedge clk);
        d_start = 1'b0;
    endtask

    // Returns at the falling edge where done is high; counts busy cycles seen.
    task automatic d_wait_done(output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 20 && !d_done; i++) begin
            if (d_busy) nbusy++;
            @(negedge clk);
        end
        if (!d_done) check("d_done_timeout", 0, 1);
    endtask

    // ------------------------------------------------------------------
    // Random instances: 16/16, 8/1, 32/8
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : 32;
        localparam int C = (g == 0) ? 16 : (g == 1) ? 1 : 8;
        localparam int N = W / C;

        logic         start = 1'b0;
        logic         sub   = 1'b0;
        logic [W-1:0] a     = '0;
        logic [W-1:0] b     = '0;
        logic         busy, done, cout, ovf;
        logic [W-1:0] sum;
        exp_t         sb[$];
        bit           fin = 1'b0;

        seq_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .sub   (sub),
            .a     (a),
            .b     (b),
            .busy  (busy),
            .done  (done),
            .sum   (sum),
            .cout  (cout),
            .ovf   (ovf)
        );

        always @(negedge clk) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check($sformatf("w%0dc%0d_spurious_done", W, C), 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("w%0dc%0d_sum", W, C), sum, e.sum);
                    check($sformatf("w%0dc%0d_cout", W, C), cout, e.cout);
                    check($sformatf("w%0dc%0d_ovf", W, C), ovf, e.ovf);
                    check($sformatf("w%0dc%0d_latency", W, C), cycle - e.t0, N);
                end
            end
        end

        initial begin
            @(posedge rst_n);
            @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                a   = W'($urandom);
                b   = W'($urandom);
                sub = 1'($urandom);
                // Bias some operations toward the sign/carry corners.
                if (n % 10 == 0) a = '1;
                if (n % 10 == 1) b = {1'b1, {(W-1){1'b0}}};
                if (n % 10 == 2) a = {1'b0, {(W-1){1'b1}}};
                start = 1'b1;
                sb.push_back(model(W, 32'(a), 32'(b), sub, cycle + 1));
                @(negedge clk);
                start = 1'b0;
                for (int i = 0; i < N + 4 && !done; i++) @(negedge clk);
                if (!done) begin
                    check($sformatf("w%0dc%0d_done_timeout", W, C), 0, 1);
                    break;
                end
            end
            fin = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [15:0] t_a   [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] t_b   [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        t_sub [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int nb;
        int nd;
        rst_n   = 1'b0;
        d_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", d_busy, 0);
        check("rst_done", d_done, 0);
        check("rst_sum", d_sum, 0);
        check("rst_cout", d_cout, 0);
        check("rst_ovf", d_ovf, 0);
        rst_n   = 1'b1;
        d_rst_n = 1'b1;
        @(negedge clk);

        // 0x00FF + 0x0001, busy for exactly N cycles, results hold after done.
        d_issue(16'h00FF, 16'h0001, 1'b0);
        d_wait_done(nb);
        check("t1_busy_cycles", nb, 4);
        check("t1_busy_at_done", d_busy, 0);
        @(negedge clk);
        check("t1_done_one_cycle", d_done, 0);
        check("t1_sum_hold", d_sum, 16'h0100);

        // Carry / overflow / borrow corners, issued back to back.
        for (int i = 0; i < 4; i++) begin
            d_issue(t_a[i], t_b[i], t_sub[i]);
            d_wait_done(nb);
        end
        @(negedge clk);

        // Start while busy is ignored; partial results show low chunks.
        d_issue(16'h1234, 16'h1111, 1'b0);
        check("ig_busy", d_busy, 1);
        check("ig_sum_cleared", d_sum, 0);
        @(negedge clk);
        check("ig_partial0", d_sum, 16'h0005);
        d_a     = 16'hFFFF;
        d_b     = 16'hFFFF;
        d_sub   = 1'b1;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        check("ig_partial1", d_sum, 16'h0045);
        d_wait_done(nb);
        check("ig_busy_rest", nb, 2);

        // Start in the done cycle is accepted.
        d_issue(16'h0102, 16'h0304, 1'b1);
        check("dc_busy", d_busy, 1);
        check("dc_done_low", d_done, 0);
        check("dc_sum_cleared", d_sum, 0);
        d_wait_done(nb);
        check("dc_busy_cycles", nb, 4);
        @(negedge clk);

        // Reset mid-operation: outputs clear at once, no done afterwards.
        d_issue(16'h1234, 16'h0001, 1'b0);
        @(negedge clk);
        d_rst_n = 1'b0;
        #1;
        d_sb.delete();
        check("abort_busy", d_busy, 0);
        check("abort_done", d_done, 0);
        check("abort_sum", d_sum, 0);
        check("abort_cout", d_cout, 0);
        check("abort_ovf", d_ovf, 0);
        @(negedge clk);
        d_rst_n = 1'b1;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_done) nd++;
        end
        check("abort_no_done", nd, 0);
        d_issue(16'h0003, 16'h0004, 1'b0);
        d_wait_done(nb);
        check("post_rst_busy_cycles", nb, 4);
        @(negedge clk);

        // Wait for the random instances, bounded.
        for (int i = 0; i < 40000 && !(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin); i++)
            @(negedge clk);
        check("rnd_complete", {g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin}, 3'b111);
        repeat (2) @(negedge clk);
        check("d_sb_empty", d_sb.size(), 0);
        check("w16c16_sb_empty", g_cfg[0].sb.size(), 0);
        check("w8c1_sb_empty", g_cfg[1].sb.size(), 0);
        check("w32c8_sb_empty", g_cfg[2].sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
